// File: rtl/raymarch_frame_sequencer_if.sv
// rtl/raymarch_frame_sequencer_if.sv - pixel output stream tap seen by the frame sequencer
interface raymarch_frame_sequencer_if;
  logic pix_valid;
  logic pix_ready;
  logic pix_sof;
  logic pix_eol;

  modport master (output pix_valid, output pix_ready, output pix_sof, output pix_eol);
  modport slave  (input  pix_valid, input  pix_ready, input  pix_sof, input  pix_eol);
endinterface

// File: rtl/raymarch_frame_sequencer.sv
// rtl/raymarch_frame_sequencer.sv - frame sequencing, staged/active scene config, pixel-stream alignment check
module raymarch_frame_sequencer #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int COORD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run_en,
  input  logic                    single_shot,
  input  logic                    cfg_commit,
  input  logic [2:0][COORD_W-1:0] light_pos_in,
  input  logic [2:0][COORD_W-1:0] camera_forward_in,
  input  logic [2:0][COORD_W-1:0] camera_right_in,
  input  logic [2:0][COORD_W-1:0] camera_up_in,
  input  logic [2:0][COORD_W-1:0] ray_origin_in,
  input  logic [2:0]              sdf_sel_in,
  raymarch_frame_sequencer_if.slave pix,
  output logic [2:0][COORD_W-1:0] light_pos,
  output logic [2:0][COORD_W-1:0] camera_forward,
  output logic [2:0][COORD_W-1:0] camera_right,
  output logic [2:0][COORD_W-1:0] camera_up,
  output logic [2:0][COORD_W-1:0] ray_origin,
  output logic [2:0]              sdf_sel,
  output logic                    pipe_rst,
  output logic                    busy,
  output logic                    commit_pending,
  output logic                    frame_done,
  output logic [15:0]             frame_count,
  output logic                    err_sync
);
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, DONE} state_t;

  typedef struct packed {
    logic [2:0][COORD_W-1:0] light_pos;
    logic [2:0][COORD_W-1:0] camera_forward;
    logic [2:0][COORD_W-1:0] camera_right;
    logic [2:0][COORD_W-1:0] camera_up;
    logic [2:0][COORD_W-1:0] ray_origin;
    logic [2:0]              sdf_sel;
  } cfg_t;

  state_t        state_q, state_d;
  cfg_t          cfg_in, staged_q, staged_d, active_q, active_d;
  logic          pending_q, pending_d, shot_q, shot_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [15:0]   count_q, count_d;
  logic          err_q, err_d, pipe_rst_q, pipe_rst_d, busy_q, busy_d, done_q, done_d;
  logic          px_fire, last_col, last_px, start_req;

  assign cfg_in    = {light_pos_in, camera_forward_in, camera_right_in, camera_up_in,
                      ray_origin_in, sdf_sel_in};
  assign px_fire   = (state_q == RUN) && pix.pix_valid && pix.pix_ready;
  assign last_col  = (col_q == CW'(WIDTH - 1));
  assign last_px   = last_col && (row_q == RW'(HEIGHT - 1));
  // A pulse arriving this cycle starts a frame without waiting for shot_q to latch it.
  assign start_req = run_en || shot_q || single_shot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_req) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = RUN;
      RUN:     if (px_fire && last_px) state_d = DONE;
      DONE:    state_d = start_req ? LOAD_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    staged_d  = cfg_commit ? cfg_in : staged_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (state_q == LOAD_A && pending_q) begin
      active_d  = staged_q;
      pending_d = 1'b0;
    end
    // A commit landing in LOAD_A is staged for the following frame.
    if (cfg_commit) pending_d = 1'b1;
    shot_d = (shot_q || single_shot) && (state_d != LOAD_A);

    col_d = col_q;
    row_d = row_q;
    err_d = err_q;
    if (state_q == LOAD_A) begin
      col_d = '0;
      row_d = '0;
      err_d = 1'b0;
    end else if (px_fire) begin
      if ((pix.pix_sof != (col_q == '0 && row_q == '0)) || (pix.pix_eol != last_col))
        err_d = 1'b1;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    pipe_rst_d = state_d inside {IDLE, LOAD_A, LOAD_B};
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    count_d    = count_q + ((state_d == DONE) ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staged_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      shot_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      pipe_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      staged_q   <= staged_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      shot_q     <= shot_d;
      col_q      <= col_d;
      row_q      <= row_d;
      count_q    <= count_d;
      err_q      <= err_d;
      pipe_rst_q <= pipe_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign light_pos      = active_q.light_pos;
  assign camera_forward = active_q.camera_forward;
  assign camera_right   = active_q.camera_right;
  assign camera_up      = active_q.camera_up;
  assign ray_origin     = active_q.ray_origin;
  assign sdf_sel        = active_q.sdf_sel;
  assign pipe_rst       = pipe_rst_q;
  assign busy           = busy_q;
  assign commit_pending = pending_q;
  assign frame_done     = done_q;
  assign frame_count    = count_q;
  assign err_sync       = err_q;
endmodule

// File: tb/tb_raymarch_frame_sequencer.sv
// tb/tb_raymarch_frame_sequencer.sv - randomized self-checking bench for raymarch_frame_sequencer
module tb_raymarch_frame_sequencer;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int NPX   = W * H;
  localparam int CFG_W = 15 * 16 + 3;

  typedef logic [2:0][15:0] vec3_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_en = 1'b0, single_shot = 1'b0, cfg_commit = 1'b0;
  vec3_t light_pos_in = '0, camera_forward_in = '0, camera_right_in = '0, camera_up_in = '0, ray_origin_in = '0;
  logic [2:0] sdf_sel_in = '0;
  vec3_t light_pos, camera_forward, camera_right, camera_up, ray_origin;
  logic [2:0] sdf_sel;
  logic pipe_rst, busy, commit_pending, frame_done, err_sync;
  logic [15:0] frame_count;

  raymarch_frame_sequencer_if pix ();

  raymarch_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .COORD_W(16)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .single_shot(single_shot), .cfg_commit(cfg_commit),
    .light_pos_in(light_pos_in), .camera_forward_in(camera_forward_in),
    .camera_right_in(camera_right_in), .camera_up_in(camera_up_in),
    .ray_origin_in(ray_origin_in), .sdf_sel_in(sdf_sel_in), .pix(pix),
    .light_pos(light_pos), .camera_forward(camera_forward), .camera_right(camera_right),
    .camera_up(camera_up), .ray_origin(ray_origin), .sdf_sel(sdf_sel),
    .pipe_rst(pipe_rst), .busy(busy), .commit_pending(commit_pending),
    .frame_done(frame_done), .frame_count(frame_count), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: configuration moves staged -> active once per frame start.
  logic [CFG_W-1:0] m_staged, m_active;
  logic             m_pending;
  logic [15:0]      m_count;

  function automatic logic [CFG_W-1:0] act_cfg();
    return {light_pos, camera_forward, camera_right, camera_up, ray_origin, sdf_sel};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_staged = '0; m_active = '0; m_pending = 1'b0; m_count = '0;
  endtask

  task automatic m_frame_start();
    if (m_pending) begin
      m_active  = m_staged;
      m_pending = 1'b0;
    end
  endtask

  task automatic set_cfg_inputs(input logic [2:0] sdf);
    for (int i = 0; i < 3; i++) begin
      light_pos_in[i]      = 16'($urandom);
      camera_forward_in[i] = 16'($urandom);
      camera_right_in[i]   = 16'($urandom);
      camera_up_in[i]      = 16'($urandom);
      ray_origin_in[i]     = 16'($urandom);
    end
    sdf_sel_in = sdf;
  endtask

  task automatic m_commit();
    m_staged  = {light_pos_in, camera_forward_in, camera_right_in, camera_up_in, ray_origin_in, sdf_sel_in};
    m_pending = 1'b1;
  endtask

  task automatic do_commit(input logic [2:0] sdf);
    set_cfg_inputs(sdf);
    cfg_commit = 1'b1;
    m_commit();
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; run_en = 1'b0; single_shot = 1'b0; cfg_commit = 1'b0;
    pix.pix_valid = 1'b0; pix.pix_ready = 1'b0; pix.pix_sof = 1'b0; pix.pix_eol = 1'b0;
    step(); step();
    rst = 1'b0;
    m_reset();
  endtask

  // bp: 0 random valid/ready, 1 valid high with ready alternating 0/1
  task automatic run_frame(input int bp, input int bad_px, input int commit_at, input int drop_at,
                           input bit start_modeled, input string tag);
    int k, cyc;
    bit exp_err, early_done, seq_bad, tog, committed, acc;
    if (!start_modeled) m_frame_start();
    pix.pix_valid = 1'b0;
    cyc = 0;
    while (pipe_rst === 1'b1 && cyc < 20) begin step(); cyc++; end
    checks++;
    if (pipe_rst !== 1'b0) begin
      errors++; $display("FAIL %s run_entry: pipe_rst=%b required 0 within 20 cycles", tag, pipe_rst);
    end
    checks++;
    if (act_cfg() !== m_active) begin
      errors++; $display("FAIL %s run_cfg: active=%h required %h", tag, act_cfg(), m_active);
    end
    checks++;
    if (err_sync !== 1'b0) begin
      errors++; $display("FAIL %s run_err_clear: err_sync=%b required 0", tag, err_sync);
    end
    k = 0; cyc = 0; exp_err = 0; early_done = 0; seq_bad = 0; tog = 0; committed = 0;
    while (k < NPX && cyc < 200) begin
      pix.pix_valid = (bp == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      pix.pix_ready = (bp == 1) ? tog : ($urandom_range(0, 3) != 0);
      tog = !tog;
      acc = pix.pix_valid && pix.pix_ready;
      if (acc) begin
        pix.pix_sof = (k == 0) ^ (k == bad_px);
        pix.pix_eol = (k % W == W - 1);
      end else begin
        pix.pix_sof = 1'($urandom_range(0, 1));
        pix.pix_eol = 1'($urandom_range(0, 1));
      end
      cfg_commit = 1'b0;
      if (k == commit_at && !committed) begin
        set_cfg_inputs(3'd5);
        cfg_commit = 1'b1;
        m_commit();
        committed = 1;
      end
      if (k == drop_at) run_en = 1'b0;
      step();
      if (acc) begin
        if (pix.pix_sof != (k == 0) || pix.pix_eol != (k % W == W - 1)) exp_err = 1;
        k++;
      end
      if (frame_done === 1'b1 && k < NPX) early_done = 1;
      if (err_sync !== exp_err) seq_bad = 1;
      cyc++;
    end
    pix.pix_valid = 1'b0;
    cfg_commit = 1'b0;
    m_count = m_count + 16'd1;
    checks++;
    if (k != NPX) begin
      errors++; $display("FAIL %s pixel_budget: accepted=%0d required %0d", tag, k, NPX);
    end
    checks++;
    if (frame_done !== 1'b1 || early_done) begin
      errors++; $display("FAIL %s frame_done: done=%b early=%0d required done=1 early=0", tag, frame_done, early_done);
    end
    checks++;
    if (frame_count !== m_count) begin
      errors++; $display("FAIL %s frame_count: got %0d required %0d", tag, frame_count, m_count);
    end
    checks++;
    if (err_sync !== exp_err || seq_bad) begin
      errors++; $display("FAIL %s err_sync: got %b required %b (trace_bad=%0d)", tag, err_sync, exp_err, seq_bad);
    end
    checks++;
    if (act_cfg() !== m_active || commit_pending !== m_pending) begin
      errors++; $display("FAIL %s end_cfg: active=%h pend=%b required %h pend=%b",
                         tag, act_cfg(), commit_pending, m_active, m_pending);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL %s done_pulse_width: frame_done=%b required 0", tag, frame_done);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (pipe_rst !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || err_sync !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: pipe_rst=%b busy=%b done=%b err=%b required 1 0 0 0",
                         pipe_rst, busy, frame_done, err_sync);
    end
    checks++;
    if (frame_count !== 16'd0 || commit_pending !== 1'b0 || act_cfg() !== '0) begin
      errors++; $display("FAIL reset_state: count=%0d pend=%b cfg=%h required 0 0 0",
                         frame_count, commit_pending, act_cfg());
    end
    for (int i = 0; i < 10; i++) begin
      pix.pix_valid = 1'b1; pix.pix_ready = 1'b1;
      pix.pix_sof = 1'($urandom_range(0, 1)); pix.pix_eol = 1'($urandom_range(0, 1));
      step();
    end
    pix.pix_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || err_sync !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: busy=%b err=%b done=%b required 0 0 0", busy, err_sync, frame_done);
    end
  endtask

  task automatic test_single_shot();
    vec3_t lp;
    lp[0] = 16'd1; lp[1] = 16'd2; lp[2] = 16'd3;
    set_cfg_inputs(3'($urandom_range(0, 7)));
    light_pos_in = lp;
    cfg_commit = 1'b1;
    m_commit();
    step();
    cfg_commit = 1'b0;
    checks++;
    if (commit_pending !== 1'b1) begin
      errors++; $display("FAIL ss_pending: commit_pending=%b required 1", commit_pending);
    end
    single_shot = 1'b1;
    m_frame_start();
    step();
    single_shot = 1'b0;
    checks++;
    if (busy !== 1'b1 || pipe_rst !== 1'b1) begin
      errors++; $display("FAIL ss_load_a: busy=%b pipe_rst=%b required 1 1", busy, pipe_rst);
    end
    step();
    checks++;
    if (light_pos !== lp || commit_pending !== 1'b0 || pipe_rst !== 1'b1) begin
      errors++; $display("FAIL ss_load_b: light_pos=%h pend=%b pipe_rst=%b required %h 0 1",
                         light_pos, commit_pending, pipe_rst, lp);
    end
    step();
    checks++;
    if (pipe_rst !== 1'b0) begin
      errors++; $display("FAIL ss_run_latency: pipe_rst=%b required 0 three cycles after pulse", pipe_rst);
    end
    run_frame(0, -1, -1, -1, 1'b1, "single_shot");
    checks++;
    if (busy !== 1'b0 || pipe_rst !== 1'b1 || frame_count !== 16'd1) begin
      errors++; $display("FAIL ss_idle: busy=%b pipe_rst=%b count=%0d required 0 1 1", busy, pipe_rst, frame_count);
    end
  endtask

  task automatic test_backpressure();
    single_shot = 1'b1; step(); single_shot = 1'b0;
    run_frame(1, -1, -1, -1, 1'b0, "backpressure");
  endtask

  task automatic test_commit_in_load();
    logic [CFG_W-1:0] old_staged;
    do_commit(3'($urandom_range(0, 7)));
    old_staged = m_staged;
    single_shot = 1'b1; step(); single_shot = 1'b0;
    m_frame_start();
    set_cfg_inputs(3'($urandom_range(0, 7)));
    cfg_commit = 1'b1;
    m_commit();
    step();
    cfg_commit = 1'b0;
    checks++;
    if (act_cfg() !== old_staged || commit_pending !== 1'b1) begin
      errors++; $display("FAIL commit_in_load: active=%h pend=%b required %h 1", act_cfg(), commit_pending, old_staged);
    end
    run_frame(0, -1, -1, -1, 1'b1, "load_commit_f1");
    single_shot = 1'b1; step(); single_shot = 1'b0;
    run_frame(0, -1, -1, -1, 1'b0, "load_commit_f2");
  endtask

  task automatic test_back_to_back();
    bit stray;
    single_shot = 1'b1;
    step(); step(); step();
    single_shot = 1'b0;
    run_frame(0, -1, -1, -1, 1'b0, "b2b_f1");
    run_frame(0, -1, -1, -1, 1'b0, "b2b_f2");
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || pipe_rst !== 1'b1) stray = 1;
      step();
    end
    checks++;
    if (stray || frame_count !== m_count) begin
      errors++; $display("FAIL b2b_collapse: extra_frame=%0d count=%0d required 0 %0d", stray, frame_count, m_count);
    end
  endtask

  task automatic test_continuous();
    apply_reset();
    do_commit(3'd2);
    run_en = 1'b1;
    run_frame(0, -1, -1, -1, 1'b0, "cont_f1");
    run_frame(0, -1, 4, -1, 1'b0, "cont_f2");
    run_frame(0, -1, -1, 4, 1'b0, "cont_f3");
    checks++;
    if (sdf_sel !== 3'd5 || frame_count !== 16'd3) begin
      errors++; $display("FAIL cont_result: sdf_sel=%0d count=%0d required 5 3", sdf_sel, frame_count);
    end
    step();
    checks++;
    if (busy !== 1'b0 || pipe_rst !== 1'b1) begin
      errors++; $display("FAIL cont_stop: busy=%b pipe_rst=%b required 0 1", busy, pipe_rst);
    end
  endtask

  task automatic test_misalign();
    single_shot = 1'b1; step(); single_shot = 1'b0;
    run_frame(0, 2, -1, -1, 1'b0, "misalign");
    checks++;
    if (err_sync !== 1'b1) begin
      errors++; $display("FAIL misalign_sticky: err_sync=%b required 1 after frame", err_sync);
    end
    single_shot = 1'b1; step(); single_shot = 1'b0;
    run_frame(0, -1, -1, -1, 1'b0, "post_misalign");
  endtask

  task automatic test_abort();
    bit seen_done;
    do_commit(3'($urandom_range(0, 7)));
    single_shot = 1'b1; step(); single_shot = 1'b0;
    step(); step();
    seen_done = 0;
    for (int k = 0; k < 5; k++) begin
      pix.pix_valid = 1'b1; pix.pix_ready = 1'b1;
      pix.pix_sof = (k == 0); pix.pix_eol = (k % W == W - 1);
      step();
      if (frame_done !== 1'b0) seen_done = 1;
    end
    pix.pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (seen_done || frame_done !== 1'b0 || busy !== 1'b0 || pipe_rst !== 1'b1 || err_sync !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl: seen_done=%0d done=%b busy=%b pipe_rst=%b err=%b required 0 0 0 1 0",
                         seen_done, frame_done, busy, pipe_rst, err_sync);
    end
    checks++;
    if (frame_count !== 16'd0 || commit_pending !== 1'b0 || act_cfg() !== '0) begin
      errors++; $display("FAIL abort_state: count=%0d pend=%b cfg=%h required 0 0 0",
                         frame_count, commit_pending, act_cfg());
    end
    step();
    rst = 1'b0;
    m_reset();
    single_shot = 1'b1; step(); single_shot = 1'b0;
    run_frame(0, -1, -1, -1, 1'b0, "after_abort");
  endtask

  task automatic test_wrap();
    force dut.count_q = 16'hFFFF;
    step();
    single_shot = 1'b1; step(); single_shot = 1'b0;
    step();
    release dut.count_q;
    m_count = 16'hFFFF;
    run_frame(0, -1, -1, -1, 1'b0, "wrap");
    checks++;
    if (frame_count !== 16'h0000) begin
      errors++; $display("FAIL wrap: frame_count=%h required 0000", frame_count);
    end
  endtask

  initial begin
    pix.pix_valid = 1'b0; pix.pix_ready = 1'b0; pix.pix_sof = 1'b0; pix.pix_eol = 1'b0;
    m_reset();
    test_reset();
    test_single_shot();
    test_backpressure();
    test_commit_in_load();
    test_back_to_back();
    test_continuous();
    test_misalign();
    test_abort();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/raymarch_frame_sequencer.md
# raymarch_frame_sequencer

Frame-level controller for the ray-marching pipeline. It holds the staged and active scene configuration: light position, camera basis, ray origin and SDF select. Staged values are promoted to the pipeline only at frame boundaries. It holds the pipeline in reset while idle and sequences frame start/stop, and it taps the pixel output stream to count frames and check SOF/EOL alignment.

## Interface
Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run_en  in  1  level; render frames back-to-back while high
- single_shot  in  1  pulse; request exactly one frame
- cfg_commit  in  1  pulse; capture all *_in config into the staged registers
- light_pos_in, camera_forward_in, camera_right_in, camera_up_in, ray_origin_in  in  vec3  staged config sources
- sdf_sel_in  in  3  staged SDF select
- pix_valid, pix_ready, pix_sof, pix_eol  in  1  taps of the pipeline output stream
- light_pos, camera_forward, camera_right, camera_up, ray_origin  out  vec3  active config driven to the pipeline
- sdf_sel  out  3  active SDF select
- pipe_rst  out  1  synchronous reset to the pipeline
- busy  out  1  high in LOAD_A, LOAD_B, RUN and DONE
- commit_pending  out  1  staged config not yet promoted
- frame_done  out  1  one-cycle pulse per completed frame
- frame_count  out  16  completed frames, wraps 0xFFFF→0
- err_sync  out  1  sticky SOF/EOL misalignment flag

## Operation
- Staging: when cfg_commit=1, all staged registers load from *_in and commit_pending is set. Commits are accepted in every state.
- A single_shot pulse sets shot_req. shot_req clears on entry to LOAD_A.
- FSM states: IDLE, LOAD_A, LOAD_B, RUN, DONE.
  - IDLE: pipe_rst=1. Go to LOAD_A if run_en or shot_req.
  - LOAD_A: pipe_rst=1. If commit_pending, copy staged→active and clear commit_pending. Clear the column/row counters and err_sync. Go to LOAD_B.
  - LOAD_B: pipe_rst=1. Go to RUN.
  - RUN: pipe_rst=0. A pixel counts on each cycle with pix_valid&&pix_ready.
    - col increments on each counted pixel. At WIDTH-1 it wraps to 0 and row increments.
    - On the counted pixel at col=HEIGHT-1... no: on the counted pixel where col=WIDTH-1 and row=HEIGHT-1, go to DONE.
  - DONE: pipe_rst=0. frame_done=1 and frame_count increments. Then go to LOAD_A if run_en or shot_req, else go to IDLE.
- Alignment check, on counted pixels only:
  - pix_sof must equal (col==0 && row==0).
  - pix_eol must equal (col==WIDTH-1).
  - Any mismatch sets err_sync. Counting continues unchanged; there is no resync.
- Handshakes that are not counted (valid without ready) never advance the counters or trigger the alignment check.

## Timing
- Reset values:
  - state=IDLE, pipe_rst=1.
  - All active and staged config = 0, sdf_sel=0.
  - commit_pending=0, shot_req=0, busy=0, frame_done=0, frame_count=0, err_sync=0.
- rst asserted mid-frame aborts the frame and returns everything to the reset values. No frame_done pulse is issued.
- Request to first RUN cycle: a request sampled in IDLE at cycle N puts LOAD_A at N+1, LOAD_B at N+2, and RUN at N+3, where pipe_rst first reads 0.
- Last counted pixel sampled at cycle M gives DONE (frame_done=1) at M+1. The next state at M+2 is LOAD_A or IDLE.
- All outputs are registered. Active config changes only on the cycle after LOAD_A and is stable through RUN.
- cfg_commit in the same cycle as LOAD_A:
  - active takes the old staged values.
  - staged takes the new values.
  - commit_pending stays 1.
- cfg_commit during RUN or DONE is staged only and is applied in the next LOAD_A.
- single_shot during busy is latched and runs one extra frame after DONE.
- Multiple single_shot pulses before LOAD_A collapse into one frame.
- run_en deasserted mid-RUN: the current frame completes, then the FSM goes to IDLE.
- pix_* inputs are ignored outside RUN.

## Test plan
- Use WIDTH=4, HEIGHT=2 throughout.
- Single shot: commit light_pos=(1,2,3), pulse single_shot, then drive 8 handshakes with correct SOF/EOL. Required:
  - active light_pos=(1,2,3) from LOAD_B onward.
  - RUN is entered 3 cycles after the pulse.
  - frame_done pulses once, frame_count=1, then IDLE with pipe_rst=1.
- Back-pressure: in RUN, alternate pix_ready 0/1 with pix_valid=1. Required: only 8 accepted handshakes end the frame; err_sync=0.
- Continuous mode: hold run_en=1 for 3 frames, and pulse cfg_commit with sdf_sel_in=5 mid-frame 2. Required:
  - sdf_sel stays at its old value until LOAD_A of frame 3, and is 5 from then on.
  - frame_count=3.
- Misalignment: assert pix_sof on pixel 3. Required: err_sync=1 sticky, frame still ends after pixel 8, err_sync cleared at the next LOAD_A.
- Abort: assert rst at pixel 5. Required: all outputs at reset values, no frame_done. After reset, single_shot runs a full 8-pixel frame.
- Wrap: preload frame_count=0xFFFF via 65535 frames, or force it in the bench. Required: the next frame wraps frame_count to 0.
